// File: rtl/fifo_wr_arb.sv
// ============================================================================
// fifo_wr_arb: packet round-robin arbiter for the link FIFO write port. Build with ARB_STATS_EN for per-requester packet counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arb #(
    parameter int DATA_WIDTH    = 44,
    parameter int DEPTH_WIDTH   = 9,
    parameter int MAX_PKT_WORDS = 64
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_last,
    input  logic [DATA_WIDTH-1:0]  req_data0,
    input  logic [DATA_WIDTH-1:0]  req_data1,
    output logic [1:0]             req_ready,
    output logic                   fifo_wr_en,
    output logic [DATA_WIDTH-1:0]  fifo_wr_data,
    input  logic                   fifo_wr_full,
    input  logic [DEPTH_WIDTH:0]   fifo_wr_water_level,
    output logic [1:0]             grant,
    output logic                   err_oversize,
    output logic [15:0]            pkt_cnt0,
    output logic [15:0]            pkt_cnt1
);

    localparam int                 C_LVL_W     = DEPTH_WIDTH + 2;
    localparam logic [C_LVL_W-1:0] C_MAX_PKT   = C_LVL_W'(MAX_PKT_WORDS);
    localparam logic [C_LVL_W-1:0] C_CAPACITY  = C_LVL_W'(2 ** DEPTH_WIDTH);
    localparam logic [7:0]         C_LAST_BEAT = 8'(MAX_PKT_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic                    hold_cnt_q, hold_cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    err_q, err_d;

    logic [C_LVL_W-1:0]      w_level_sum;
    logic                    w_space_ok;
    logic                    w_gidx;
    logic                    w_beat_valid;
    logic                    w_beat_last;
    logic [DATA_WIDTH-1:0]   w_beat_data;
    logic                    w_accept;
    logic                    w_pick;

    // Admission needs room for a full maximum-size packet, so a granted
    // packet never sees back-pressure under normal operation.
    assign w_level_sum  = {1'b0, fifo_wr_water_level} + C_MAX_PKT;
    assign w_space_ok   = (w_level_sum <= C_CAPACITY) && !fifo_wr_full;

    assign w_gidx       = grant_q[1];
    assign w_beat_valid = req_valid[w_gidx];
    assign w_beat_last  = req_last[w_gidx];
    assign w_beat_data  = w_gidx ? req_data1 : req_data0;
    assign w_accept     = w_beat_valid && req_ready[w_gidx];
    assign w_pick       = (&req_valid) ? ~last_grant_q : req_valid[1];

    always_comb begin
        req_ready = 2'b00;
        case (state_q)
            S_XFER:  req_ready[w_gidx] = !fifo_wr_full;
            S_DROP:  req_ready[w_gidx] = 1'b1;
            default: req_ready = 2'b00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_space_ok && (|req_valid)) begin
                    state_d      = S_XFER;
                    grant_d      = w_pick ? 2'b10 : 2'b01;
                    last_grant_d = w_pick;
                    beat_cnt_d   = 8'd0;
                end
            end
            S_XFER: begin
                if (w_accept) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = w_beat_data;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (w_beat_last) begin
                        state_d    = S_HOLD;
                        grant_d    = 2'b00;
                        hold_cnt_d = 1'b0;
                    end else if (beat_cnt_q == C_LAST_BEAT) begin
                        state_d = S_DROP;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (w_accept && w_beat_last) begin
                    state_d    = S_HOLD;
                    grant_d    = 2'b00;
                    hold_cnt_d = 1'b0;
                end
            end
            S_HOLD: begin
                // Two idle cycles let the water level catch up with the last write.
                hold_cnt_d = 1'b1;
                if (hold_cnt_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 8'd0;
            hold_cnt_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            err_q        <= err_d;
        end
    end

    assign grant        = grant_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign err_oversize = err_q;

`ifdef ARB_STATS_EN
    logic [15:0] pkt_cnt0_q;
    logic [15:0] pkt_cnt1_q;
    logic        w_pkt_done;

    // Only packets that finish inside XFER count; truncated ones end in DROP.
    assign w_pkt_done = (state_q == S_XFER) && w_accept && w_beat_last;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            pkt_cnt0_q <= 16'd0;
            pkt_cnt1_q <= 16'd0;
        end else if (w_pkt_done) begin
            if (w_gidx) begin
                pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
            end else begin
                pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
            end
        end
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
`else
    assign pkt_cnt0 = 16'd0;
    assign pkt_cnt1 = 16'd0;
`endif

endmodule

`default_nettype wire
